// File: rtl/usb3_rx_align_descram_if.sv
// PIPE receive word and link-layer output handshake for the RX align/descramble block.
// The master side feeds received words and consumes aligned output words.
interface usb3_rx_align_descram_if #(
  parameter int BYTES = 4
);
  localparam int PW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic                 in_valid;
  logic [8*BYTES-1:0]   in_data;
  logic [BYTES-1:0]     in_datak;
  logic                 out_ready;
  logic                 out_valid;
  logic [8*BYTES-1:0]   out_data;
  logic [BYTES-1:0]     out_datak;
  logic [PW-1:0]        out_com_pos;

  modport master (
    output in_valid, in_data, in_datak, out_ready,
    input  out_valid, out_data, out_datak, out_com_pos
  );

  modport slave (
    input  in_valid, in_data, in_datak, out_ready,
    output out_valid, out_data, out_datak, out_com_pos
  );
endinterface

// File: rtl/usb3_rx_align_descram.sv
// USB 3.0 RX front-end: SKP removal, byte repacking through an accumulator,
// and per-byte descrambling with LFSR reseed on COM.
module usb3_rx_align_descram #(
  parameter int          BYTES     = 4,
  parameter int          ACC_BYTES = 12,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF,
  parameter logic [7:0]  SKP_SYM   = 8'h3C,
  parameter logic [7:0]  COM_SYM   = 8'hBC
) (
  input  logic                  local_clk,
  input  logic                  reset,
  input  logic                  descram_en,
  usb3_rx_align_descram_if.slave bus,
  output logic [7:0]            err_skp_gap,
  output logic                  err_overflow
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int OW = $clog2(ACC_BYTES + 1);
  localparam int PW = (BYTES > 1) ? $clog2(BYTES) : 1;

  if (BYTES != 2 && BYTES != 4) begin : g_bad_bytes
    $error("BYTES must be 2 or 4");
  end
  if (ACC_BYTES < 3 * BYTES) begin : g_bad_acc
    $error("ACC_BYTES must be at least 3*BYTES");
  end

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int n = 0; n < 8; n++) r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
    return r;
  endfunction

  // Scrambler output bit i is taken from LFSR bit 15-i.
  function automatic logic [7:0] lfsr_byte(input logic [15:0] s);
    logic [7:0] b;
    b = '0;
    for (int n = 0; n < 8; n++) b[n] = s[15-n];
    return b;
  endfunction

  logic [BYTES-1:0] skp_mask;
  logic             skp_gap, seen_skp, seen_hole;
  logic [7:0]       strip_data [BYTES];
  logic [BYTES-1:0] strip_k;
  logic [CW-1:0]    strip_cnt;

  always_comb begin
    skp_mask  = '0;
    skp_gap   = 1'b0;
    seen_skp  = 1'b0;
    seen_hole = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      skp_mask[i] = bus.in_datak[i] && (bus.in_data[8*i +: 8] == SKP_SYM);
      if (skp_mask[i]) begin
        if (seen_hole) skp_gap = 1'b1;
        seen_skp = 1'b1;
      end else if (seen_skp) begin
        seen_hole = 1'b1;
      end
    end
  end

  always_comb begin
    strip_data = '{default: 8'h00};
    strip_k    = '0;
    strip_cnt  = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (!skp_mask[i]) begin
        strip_data[strip_cnt[PW-1:0]] = bus.in_data[8*i +: 8];
        strip_k[strip_cnt[PW-1:0]]    = bus.in_datak[i];
        strip_cnt = strip_cnt + CW'(1);
      end
    end
  end

  logic [7:0]       s1_data [BYTES];
  logic [BYTES-1:0] s1_k;
  logic [CW-1:0]    s1_cnt;

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      s1_data     <= '{default: 8'h00};
      s1_k        <= '0;
      s1_cnt      <= '0;
      err_skp_gap <= '0;
    end else begin
      s1_data <= strip_data;
      s1_k    <= strip_k;
      s1_cnt  <= bus.in_valid ? strip_cnt : '0;
      if (bus.in_valid && skp_gap && err_skp_gap != 8'hFF) err_skp_gap <= err_skp_gap + 8'd1;
    end
  end

  logic [7:0]           acc_data   [ACC_BYTES];
  logic [7:0]           acc_data_n [ACC_BYTES];
  logic [ACC_BYTES-1:0] acc_k, acc_k_n;
  logic [OW-1:0]        occ, occ_keep, occ_n;
  logic                 pop, fits;

  assign pop      = (occ >= OW'(BYTES)) && (!bus.out_valid || bus.out_ready);
  assign occ_keep = pop ? occ - OW'(BYTES) : occ;
  // A fragment that does not fit is dropped whole so no partial word ever forms.
  assign fits     = ({1'b0, occ_keep} + {1'b0, OW'(s1_cnt)}) <= (OW+1)'(ACC_BYTES);
  assign occ_n    = fits ? occ_keep + OW'(s1_cnt) : occ_keep;

  always_comb begin
    acc_data_n = acc_data;
    acc_k_n    = acc_k;
    if (pop) begin
      for (int j = 0; j < ACC_BYTES - BYTES; j++) begin
        acc_data_n[j] = acc_data[j+BYTES];
        acc_k_n[j]    = acc_k[j+BYTES];
      end
      for (int j = ACC_BYTES - BYTES; j < ACC_BYTES; j++) begin
        acc_data_n[j] = 8'h00;
        acc_k_n[j]    = 1'b0;
      end
    end
    if (fits) begin
      for (int i = 0; i < BYTES; i++) begin
        if (CW'(i) < s1_cnt) begin
          acc_data_n[occ_keep + OW'(i)] = s1_data[i];
          acc_k_n[occ_keep + OW'(i)]    = s1_k[i];
        end
      end
    end
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      acc_data     <= '{default: 8'h00};
      acc_k        <= '0;
      occ          <= '0;
      err_overflow <= 1'b0;
    end else begin
      acc_data <= acc_data_n;
      acc_k    <= acc_k_n;
      occ      <= occ_n;
      if (!fits) err_overflow <= 1'b1;
    end
  end

  logic [15:0]        lfsr, lfsr_w;
  logic [8*BYTES-1:0] dsc_data;
  logic [BYTES-1:0]   dsc_k;
  logic               com_hit;
  logic [PW-1:0]      com_idx;

  always_comb begin
    lfsr_w   = lfsr;
    dsc_data = '0;
    dsc_k    = '0;
    com_hit  = 1'b0;
    com_idx  = '0;
    for (int i = 0; i < BYTES; i++) begin
      dsc_k[i] = acc_k[i];
      if (acc_k[i] && acc_data[i] == COM_SYM) begin
        dsc_data[8*i +: 8] = acc_data[i];
        com_hit = 1'b1;
        com_idx = PW'(i);
        lfsr_w  = LFSR_SEED;
      end else if (acc_k[i]) begin
        dsc_data[8*i +: 8] = acc_data[i];
        lfsr_w = lfsr_adv8(lfsr_w);
      end else begin
        dsc_data[8*i +: 8] = acc_data[i] ^ (descram_en ? lfsr_byte(lfsr_w) : 8'h00);
        lfsr_w = lfsr_adv8(lfsr_w);
      end
    end
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_datak   <= '0;
      bus.out_com_pos <= '0;
      lfsr            <= LFSR_SEED;
    end else begin
      if (pop) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= dsc_data;
        bus.out_datak <= dsc_k;
        if (com_hit) bus.out_com_pos <= com_idx;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (!descram_en) lfsr <= LFSR_SEED;
      else if (pop) lfsr <= lfsr_w;
    end
  end

endmodule
